// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit with architectural HI/LO.
// One bit per clock; signed ops run on magnitudes and fix the sign at writeback.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   ma, mbm;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod;
  logic [WIDTH:0]     div_shift, div_trial;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem_n, div_quo_n;

  // Operand magnitudes for signed ops
  always_comb begin
    ma  = (op[0] && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    mbm = (op[0] && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;
  end

  // One iteration of each datapath; acc_hi is partial product / remainder,
  // acc_lo is shifting multiplier / dividend-into-quotient.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mb_q : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc_lo_q[WIDTH-1:1]};
    prod      = neg_q ? ({(2*WIDTH){1'b0}} - mul_next) : mul_next;
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, mb_q};
    div_ok    = ~div_trial[WIDTH];
    div_rem_n = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_n = {acc_lo_q[WIDTH-2:0], div_ok};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mb_d     = mb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = 1'b0;

    // MTHI/MTLO are accepted whenever no operation is running
    if (state_q != RUN) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acc_hi_d = {WIDTH{1'b0}};
          acc_lo_d = ma;
          mb_d     = mbm;
          is_div_d = op[1];
          neg_d    = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d   = op[0] & a[WIDTH-1];
          cnt_d    = CW'(WIDTH - 1);
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          acc_hi_d = div_rem_n;
          acc_lo_d = div_quo_n;
        end else begin
          acc_hi_d = mul_next[2*WIDTH-1:WIDTH];
          acc_lo_d = mul_next[WIDTH-1:0];
        end
        if (cnt_q == {CW{1'b0}}) begin
          state_d = DONE;
          if (!is_div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (mb_q == {WIDTH{1'b0}}) begin
            dbz_d = 1'b1;
          end else begin
            lo_d = neg_q  ? ({WIDTH{1'b0}} - div_quo_n) : div_quo_n;
            hi_d = rneg_q ? ({WIDTH{1'b0}} - div_rem_n) : div_rem_n;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mb_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mb_q     <= mb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit at WIDTH=32 using hand-computed vectors.
module tb_mul_div_unit;

  localparam int unsigned W = 32;

  logic         clk, reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    time          t0;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          chk("latency_cycles", 64'(($time - e.t0 + 5) / 10), 64'd33);
          chk("busy_cycles", 64'(busy_cnt), 64'(W));
        end
        busy_cnt = 0;
      end else begin
        chk("dbz_outside_done", 64'(div_by_zero), 64'd0);
      end
    end
  end

  // Called at a negedge; drives start for exactly one rising edge
  task automatic issue(input logic [1:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    exp_t e;
    e.hi = eh; e.lo = el; e.dbz = ed; e.t0 = $time + 5;
    sb.push_back(e);
    start = 1'b1; op = o; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is visible
  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    wait_done();
    @(negedge clk);

    // MT writes during RUN are dropped; HI/LO hold pre-operation values
    issue(2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    repeat (4) @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("hi_we_busy_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("hi_we_busy_lo", 64'(lo), 64'h0000_0001);
    wait_done();

    // Back-to-back launches from the DONE cycle
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done();
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    wait_done();
    @(negedge clk);

    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_5678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mthi", 64'(hi), 64'h1234);
    chk("mtlo", 64'(lo), 64'h5678);
    issue(2'b10, 32'd100, 32'd0, 32'h0000_1234, 32'h0000_5678, 1'b1);
    wait_done();
    @(negedge clk);

    // Re-pulsed start and operand changes mid-RUN are ignored
    issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0; a = 32'd0; b = 32'd0;
    wait_done();
    issue(2'b00, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 1'b0);
    wait_done();
    @(negedge clk);

    // MTHI on the start edge lands, then the result overwrites it
    hi_we = 1'b1; wdata = 32'h0000_AAAA;
    issue(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    hi_we = 1'b0;
    chk("mthi_with_start", 64'(hi), 64'hAAAA);
    wait_done();
    @(negedge clk);

    issue(2'b10, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
    wait_done();
    issue(2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    wait_done();
    issue(2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 1'b0);
    wait_done();
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0);
    wait_done();
    @(negedge clk);

    // Asynchronous reset in the middle of RUN
    issue(2'b00, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_hi", 64'(hi), 64'd0);
    chk("async_rst_lo", 64'(lo), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_done", 64'(done), 64'd0);

    issue(2'b10, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
